// File: rtl/tx_power_gate.sv
// TX power gate: delays host samples and forwards them to the DUC only
// while instantaneous power keeps the gate open, with pre-roll and hang.
module tx_power_gate #(
   parameter int WIDTH  = 24,
   parameter int BASE   = 0,
   parameter int AWIDTH = 9
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic             set_stb,
   input  logic [7:0]       set_addr,
   input  logic [31:0]      set_data,
   input  logic [WIDTH-1:0] duc_out_i,
   input  logic [WIDTH-1:0] duc_out_q,
   output logic [WIDTH-1:0] frontend_i,
   output logic [WIDTH-1:0] frontend_q,
   output logic [31:0]      duc_in_sample,
   input  logic             duc_in_strobe,
   output logic             duc_in_enable,
   input  logic [31:0]      bb_sample,
   output logic             bb_strobe,
   output logic             gate_open,
   output logic [15:0]      burst_count
);

   localparam int DEPTH = 1 << AWIDTH;

   localparam logic [7:0] A_THRESH = 8'(BASE);
   localparam logic [7:0] A_HANG   = 8'(BASE + 1);
   localparam logic [7:0] A_CTRL   = 8'(BASE + 2);

   localparam logic [1:0] S_FILL = 2'd0;
   localparam logic [1:0] S_IDLE = 2'd1;
   localparam logic [1:0] S_OPEN = 2'd2;
   localparam logic [1:0] S_HANG = 2'd3;

   logic [31:0]       thresh;
   logic [15:0]       hang;
   logic              bypass;

   logic              flush;
   logic              stb;
   logic              gate_cond;

   logic [AWIDTH-1:0] wr_addr;
   logic [AWIDTH-1:0] rd_addr;
   logic [31:0]       mem [DEPTH];
   logic [31:0]       rd_data;

   logic signed [15:0] s_i;
   logic signed [15:0] s_q;
   logic signed [31:0] prod_i;
   logic signed [31:0] prod_q;
   logic [31:0]       sq_i;
   logic [31:0]       sq_q;
   logic [31:0]       pwr;

   logic              v1;
   logic              v2;
   logic              wrap1;
   logic              wrap2;
   logic              sel1;
   logic              above;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [15:0]       cnt;
   logic [15:0]       cnt_nxt;
   logic              burst_inc;
   logic              open_nxt;

   assign frontend_i    = duc_out_i;
   assign frontend_q    = duc_out_q;
   assign duc_in_enable = enable;
   assign bb_strobe     = duc_in_strobe & enable;

   assign flush   = clear | ~enable;
   assign stb     = bb_strobe & ~clear;
   assign rd_addr = wr_addr + 1'b1;

   assign gate_cond = (state == S_OPEN) ||
                      (state == S_HANG) ||
                      (bypass && (state != S_FILL));

   assign s_i    = bb_sample[31:16];
   assign s_q    = bb_sample[15:0];
   assign prod_i = s_i * s_i;
   assign prod_q = s_q * s_q;
   // each square is at most 2^30, so the sum cannot overflow 32 bits
   assign pwr    = sq_i + sq_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         thresh <= '0;
         hang   <= '0;
         bypass <= 1'b0;
      end else if (set_stb) begin
         if (set_addr == A_THRESH)
            thresh <= set_data;
         if (set_addr == A_HANG)
            hang <= set_data[15:0];
         if (set_addr == A_CTRL)
            bypass <= set_data[0];
      end
   end

   // read slot is the oldest entry, D strobes behind the write
   always_ff @(posedge clock) begin
      if (stb) begin
         mem[wr_addr] <= bb_sample;
         rd_data      <= mem[rd_addr];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_addr <= '0;
         v1      <= 1'b0;
         v2      <= 1'b0;
         wrap1   <= 1'b0;
         wrap2   <= 1'b0;
         sel1    <= 1'b0;
         sq_i    <= '0;
         sq_q    <= '0;
         above   <= 1'b0;
      end else if (flush) begin
         wr_addr <= '0;
         v1      <= 1'b0;
         v2      <= 1'b0;
         wrap1   <= 1'b0;
         wrap2   <= 1'b0;
         sel1    <= 1'b0;
         sq_i    <= '0;
         sq_q    <= '0;
         above   <= 1'b0;
      end else begin
         v1    <= stb;
         wrap1 <= stb && (wr_addr == '1);
         v2    <= v1;
         wrap2 <= wrap1;
         if (stb) begin
            wr_addr <= rd_addr;
            sel1    <= gate_cond;
            sq_i    <= prod_i;
            sq_q    <= prod_q;
         end
         if (v1)
            above <= pwr > thresh;
      end
   end

   // holds its last word across clear/disable
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         duc_in_sample <= '0;
      else if (v1 && !flush)
         duc_in_sample <= sel1 ? rd_data : '0;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      burst_inc = 1'b0;
      if (v2) begin
         unique case (1'b1)
            (state == S_FILL): begin
               if (wrap2)
                  state_nxt = S_IDLE;
            end
            (state == S_IDLE): begin
               if (above) begin
                  state_nxt = S_OPEN;
                  burst_inc = 1'b1;
               end
            end
            (state == S_OPEN): begin
               if (!above) begin
                  if (hang == 16'd0) begin
                     state_nxt = S_IDLE;
                  end else begin
                     state_nxt = S_HANG;
                     cnt_nxt   = hang;
                  end
               end
            end
            (state == S_HANG): begin
               if (above) begin
                  state_nxt = S_OPEN;
               end else begin
                  cnt_nxt = cnt - 16'd1;
                  if (cnt == 16'd1)
                     state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_FILL;
         endcase
      end
      open_nxt = (state_nxt == S_OPEN) ||
                 (state_nxt == S_HANG);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_FILL;
         cnt         <= '0;
         gate_open   <= 1'b0;
         burst_count <= '0;
      end else if (flush) begin
         state     <= S_FILL;
         cnt       <= '0;
         gate_open <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         gate_open <= open_nxt;
         if (burst_inc && (burst_count != 16'hFFFF))
            burst_count <= burst_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_tx_power_gate.sv
// Directed bench for tx_power_gate with a 16-entry delay line (D = 15).
// Strobes are spaced 6 clocks apart so each result settles before checking.
module tb_tx_power_gate;

   localparam int WIDTH = 24;
   localparam int AW    = 4;

   localparam logic [31:0] Z    = 32'h0000_0000;
   localparam logic [31:0] P100 = 32'h0064_0000;
   localparam logic [31:0] P200 = 32'h00C8_0000;
   localparam logic [31:0] Q40  = 32'h0000_0028;
   localparam logic [31:0] IQ41 = 32'h0001_0028;
   localparam logic [31:0] PMAX = 32'h8000_7FFF;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             clear = 1'b0;
   logic             enable = 1'b0;
   logic             set_stb = 1'b0;
   logic [7:0]       set_addr = '0;
   logic [31:0]      set_data = '0;
   logic [WIDTH-1:0] duc_out_i = '0;
   logic [WIDTH-1:0] duc_out_q = '0;
   logic [WIDTH-1:0] frontend_i;
   logic [WIDTH-1:0] frontend_q;
   logic [31:0]      duc_in_sample;
   logic             duc_in_strobe = 1'b0;
   logic             duc_in_enable;
   logic [31:0]      bb_sample = '0;
   logic             bb_strobe;
   logic             gate_open;
   logic [15:0]      burst_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_byp [11] = '{
      P200, Z, Z, Z, Z, Z, P200, Z, Q40, Q40, IQ41
   };

   tx_power_gate #(
      .WIDTH(WIDTH),
      .BASE(0),
      .AWIDTH(AW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .clear(clear),
      .enable(enable),
      .set_stb(set_stb),
      .set_addr(set_addr),
      .set_data(set_data),
      .duc_out_i(duc_out_i),
      .duc_out_q(duc_out_q),
      .frontend_i(frontend_i),
      .frontend_q(frontend_q),
      .duc_in_sample(duc_in_sample),
      .duc_in_strobe(duc_in_strobe),
      .duc_in_enable(duc_in_enable),
      .bb_sample(bb_sample),
      .bb_strobe(bb_strobe),
      .gate_open(gate_open),
      .burst_count(burst_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr_set(input logic [7:0] a, input logic [31:0] d);
      @(negedge clock);
      set_stb  = 1'b1;
      set_addr = a;
      set_data = d;
      @(negedge clock);
      set_stb = 1'b0;
   endtask

   task automatic strobe(input logic [31:0] s);
      @(negedge clock);
      bb_sample     = s;
      duc_in_strobe = 1'b1;
      #1;
      check("bb_strobe", {31'b0, bb_strobe}, {31'b0, enable});
      @(negedge clock);
      duc_in_strobe = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      duc_out_i = 24'h123456;
      duc_out_q = 24'hFEDCBA;
      repeat (3) @(negedge clock);
      check("rst_sample", duc_in_sample, Z);
      check("rst_gate", {31'b0, gate_open}, 32'd0);
      check("rst_burst", {16'b0, burst_count}, 32'd0);
      check("rst_state", {30'b0, dut.state}, 32'd0);
      reset = 1'b1;
      @(negedge clock);
      check("fe_i", {8'b0, frontend_i}, 32'h0012_3456);
      check("fe_q", {8'b0, frontend_q}, 32'h00FE_DCBA);
      check("duc_en0", {31'b0, duc_in_enable}, 32'd0);

      wr_set(8'd0, 32'd1000);
      wr_set(8'd1, 32'd20);
      enable = 1'b1;
      @(negedge clock);
      check("duc_en1", {31'b0, duc_in_enable}, 32'd1);

      for (int i = 0; i < 15; i++) begin
         strobe(P100);
         check("fill_out", duc_in_sample, Z);
         check("fill_gate", {31'b0, gate_open}, 32'd0);
         check("fill_state", {30'b0, dut.state}, 32'd0);
      end
      strobe(P100);
      check("fill_exit", {30'b0, dut.state}, 32'd1);

      for (int i = 0; i < 20; i++) strobe(Z);
      check("idle_gate", {31'b0, gate_open}, 32'd0);
      check("idle_burst", {16'b0, burst_count}, 32'd0);

      strobe(P200);
      check("open_gate", {31'b0, gate_open}, 32'd1);
      check("open_burst", {16'b0, burst_count}, 32'd1);
      check("open_out", duc_in_sample, Z);
      for (int i = 0; i < 14; i++) begin
         strobe(Z);
         check("preroll_out", duc_in_sample, Z);
         check("preroll_gate", {31'b0, gate_open}, 32'd1);
      end
      strobe(Z);
      check("delay_edge", duc_in_sample, P200);
      check("hang_state", {30'b0, dut.state}, 32'd3);
      for (int i = 0; i < 5; i++) begin
         strobe(Z);
         check("hang20_gate", {31'b0, gate_open}, 32'd1);
      end
      strobe(Z);
      check("hang20_close", {31'b0, gate_open}, 32'd0);
      strobe(Z);
      check("closed_out", duc_in_sample, Z);

      wr_set(8'd1, 32'd3);
      strobe(P200);
      check("b2_gate", {31'b0, gate_open}, 32'd1);
      check("b2_burst", {16'b0, burst_count}, 32'd2);
      for (int i = 0; i < 3; i++) begin
         strobe(Z);
         check("hang3_gate", {31'b0, gate_open}, 32'd1);
      end
      strobe(Z);
      check("hang3_close", {31'b0, gate_open}, 32'd0);
      strobe(Z);
      check("hang3_out", duc_in_sample, Z);

      strobe(P200);
      check("b3_burst", {16'b0, burst_count}, 32'd3);
      strobe(Z);
      check("b3_hang", {30'b0, dut.state}, 32'd3);
      strobe(Q40);
      check("reopen_state", {30'b0, dut.state}, 32'd2);
      check("reopen_burst", {16'b0, burst_count}, 32'd3);
      wr_set(8'd0, 32'd1600);
      strobe(Q40);
      check("eq_thresh", {30'b0, dut.state}, 32'd3);
      check("eq_gate", {31'b0, gate_open}, 32'd1);
      strobe(IQ41);
      check("gt_thresh", {30'b0, dut.state}, 32'd2);
      check("gt_burst", {16'b0, burst_count}, 32'd3);
      for (int i = 0; i < 3; i++) strobe(Z);
      check("b3_gate_hi", {31'b0, gate_open}, 32'd1);
      strobe(Z);
      check("b3_close", {31'b0, gate_open}, 32'd0);

      wr_set(8'd0, 32'hFFFF_FFFF);
      wr_set(8'd2, 32'd1);
      for (int i = 0; i < 11; i++) begin
         strobe(Z);
         check("byp_out", duc_in_sample, exp_byp[i]);
         check("byp_gate", {31'b0, gate_open}, 32'd0);
      end

      wr_set(8'd2, 32'd0);
      wr_set(8'd0, 32'h7FFF_0000);
      strobe(PMAX);
      check("max_gate", {31'b0, gate_open}, 32'd1);
      check("max_burst", {16'b0, burst_count}, 32'd4);
      wr_set(8'd1, 32'd20);
      for (int i = 0; i < 14; i++) strobe(Z);
      check("max_pre", duc_in_sample, Z);
      strobe(Z);
      check("max_out", duc_in_sample, PMAX);
      check("max_hang", {30'b0, dut.state}, 32'd3);

      @(negedge clock);
      enable = 1'b0;
      @(negedge clock);
      check("dis_state", {30'b0, dut.state}, 32'd0);
      check("dis_gate", {31'b0, gate_open}, 32'd0);
      check("dis_hold", duc_in_sample, PMAX);
      check("dis_burst", {16'b0, burst_count}, 32'd4);
      strobe(32'h1234_5678);
      check("dis_hold2", duc_in_sample, PMAX);
      enable = 1'b1;
      strobe(Z);
      check("reen_out", duc_in_sample, Z);
      check("reen_gate", {31'b0, gate_open}, 32'd0);

      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("arst_burst", {16'b0, burst_count}, 32'd0);
      check("arst_out", duc_in_sample, Z);
      check("arst_gate", {31'b0, gate_open}, 32'd0);
      check("arst_state", {30'b0, dut.state}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
